// File: rtl/key_debounce_reader.sv
// key_debounce_reader: push-button synchronizer, debouncer, press counter.
// Optional long-press detector built when KEY_LONG_PRESS_EN is defined.
module key_debounce_reader #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic       EXTCLK,
  input  logic       RESET_N,
  input  logic       KEY_IN,
  input  logic       COUNT_CLR,
  output logic       KEY_LEVEL,
  output logic       KEY_PRESS,
  output logic       KEY_RELEASE,
  output logic       KEY_LONG,
  output logic [7:0] PRESS_COUNT
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sync_1;
  logic          sync_n;
  logic          press_acc;
  logic          rel_acc;
  logic          holding;

  // Two-flop synchronizer; idles high (button released).
  always_ff @(posedge EXTCLK) begin
    if (!RESET_N) begin
      sync_1 <= 1'b1;
      sync_n <= 1'b1;
    end else begin
      sync_1 <= KEY_IN;
      sync_n <= sync_1;
    end
  end

  assign press_acc = (state == PRESS_WAIT) &&
                     !sync_n && (cnt == CNT_LAST);
  assign rel_acc   = (state == RELEASE_WAIT) &&
                     sync_n && (cnt == CNT_LAST);
  assign holding   = (state == PRESSED) ||
                     (state == RELEASE_WAIT);

  // Debounce FSM with registered level, pulses and press count.
  always_ff @(posedge EXTCLK) begin
    if (!RESET_N) begin
      state       <= IDLE;
      cnt         <= '0;
      KEY_LEVEL   <= 1'b0;
      KEY_PRESS   <= 1'b0;
      KEY_RELEASE <= 1'b0;
      PRESS_COUNT <= 8'h00;
    end else begin
      KEY_PRESS   <= 1'b0;
      KEY_RELEASE <= 1'b0;
      if (COUNT_CLR)
        PRESS_COUNT <= 8'h00;
      unique case (state)
        IDLE: begin
          if (!sync_n) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (sync_n) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= PRESSED;
            cnt       <= '0;
            KEY_PRESS <= 1'b1;
            KEY_LEVEL <= 1'b1;
            // Clear wins first, then this press counts.
            PRESS_COUNT <= COUNT_CLR ? 8'h01
                         : PRESS_COUNT + 8'h01;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (sync_n) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (!sync_n) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            KEY_RELEASE <= 1'b1;
            KEY_LEVEL   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int HW =
    (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  logic [HW-1:0] hold;

  // Hold timer: runs while pressed, saturates, fires once.
  always_ff @(posedge EXTCLK) begin
    if (!RESET_N) begin
      hold     <= '0;
      KEY_LONG <= 1'b0;
    end else begin
      KEY_LONG <= 1'b0;
      if (press_acc || rel_acc) begin
        hold <= '0;
      end else if (holding && hold != HOLD_LAST) begin
        hold     <= hold + HOLD_ONE;
        KEY_LONG <= (hold == HOLD_LAST - HOLD_ONE);
      end
    end
  end
`else
  logic unused_ok;
  assign unused_ok = press_acc ^ rel_acc ^ holding;
  // Feature compiled out: long-press output is tied low.
  assign KEY_LONG = (LONG_CYCLES < 0) & unused_ok;
`endif

endmodule

// File: tb/tb_key_debounce_reader.sv
// tb_key_debounce_reader: random + directed checks against a
// run-length debounce reference model (DEBOUNCE=4, LONG=10).
module tb_key_debounce_reader;

  localparam int D = 4;
  localparam int L = 10;

  logic       EXTCLK;
  logic       RESET_N;
  logic       KEY_IN;
  logic       COUNT_CLR;
  logic       KEY_LEVEL;
  logic       KEY_PRESS;
  logic       KEY_RELEASE;
  logic       KEY_LONG;
  logic [7:0] PRESS_COUNT;

  int n_chk  = 0;
  int n_fail = 0;

  key_debounce_reader #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L)
  ) dut (
    .EXTCLK(EXTCLK),
    .RESET_N(RESET_N),
    .KEY_IN(KEY_IN),
    .COUNT_CLR(COUNT_CLR),
    .KEY_LEVEL(KEY_LEVEL),
    .KEY_PRESS(KEY_PRESS),
    .KEY_RELEASE(KEY_RELEASE),
    .KEY_LONG(KEY_LONG),
    .PRESS_COUNT(PRESS_COUNT)
  );

  initial begin
    EXTCLK = 1'b0;
    forever #5 EXTCLK = ~EXTCLK;
  end

  // Reference model: a level change is accepted once the
  // synchronized key has disagreed with the level for D
  // consecutive samples; the key path has 2 samples of delay.
  logic       m_s1, m_s2;
  logic       m_lvl, m_prs, m_rel, m_lng;
  logic [7:0] m_cnt;
  int         m_run, m_hold;

  task automatic model_step();
    logic smp;
    logic was;
    if (!RESET_N) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_lvl = 1'b0; m_prs = 1'b0;
      m_rel = 1'b0; m_lng = 1'b0;
      m_cnt = 8'h00; m_run = 0; m_hold = 0;
    end else begin
      smp  = m_s2;
      m_s2 = m_s1;
      m_s1 = KEY_IN;
      m_prs = 1'b0; m_rel = 1'b0; m_lng = 1'b0;
      was = m_lvl;
      if ((smp == 1'b0) != m_lvl) begin
        m_run++;
        if (m_run == D) begin
          m_run = 0;
          m_lvl = !m_lvl;
          if (m_lvl) m_prs = 1'b1;
          else m_rel = 1'b1;
        end
      end else begin
        m_run = 0;
      end
      if (m_prs)
        m_cnt = COUNT_CLR ? 8'h01 : m_cnt + 8'h01;
      else if (COUNT_CLR)
        m_cnt = 8'h00;
`ifdef KEY_LONG_PRESS_EN
      if (m_prs || m_rel) begin
        m_hold = 0;
      end else if (was && m_hold < L - 1) begin
        m_hold++;
        if (m_hold == L - 1) m_lng = 1'b1;
      end
`else
      if (was) m_hold = 0;
`endif
    end
  endtask

  task automatic tick(input logic k, input logic c);
    KEY_IN    = k;
    COUNT_CLR = c;
    @(posedge EXTCLK);
    model_step();
    @(negedge EXTCLK);
  endtask

  task automatic test_reset();
    int e;
    bit seen;
    RESET_N = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      n_chk++;
      if ({KEY_LEVEL, KEY_PRESS, KEY_RELEASE,
           KEY_LONG, PRESS_COUNT} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=000",
          i, {KEY_LEVEL, KEY_PRESS, KEY_RELEASE,
              KEY_LONG, PRESS_COUNT});
      end
    end
    RESET_N = 1'b1;
    e = 0;
    seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick(1'b0, 1'b0);
      if (KEY_PRESS) begin
        seen = 1;
        e = i;
      end
    end
    n_chk++;
    if (e != D + 2) begin
      n_fail++;
      $display("FAIL reset_press_edge got=%0d exp=%0d",
        e, D + 2);
    end
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
  endtask

  task automatic test_clean_press();
    int e;
    logic [7:0] c0;
    c0 = PRESS_COUNT;
    e = 0;
    for (int i = 1; i <= 20 && e == 0; i++) begin
      tick(1'b0, 1'b0);
      if (KEY_PRESS) e = i;
    end
    n_chk++;
    if (e != D + 2) begin
      n_fail++;
      $display("FAIL press_edge got=%0d exp=%0d", e, D + 2);
    end
    n_chk++;
    if (KEY_LEVEL !== 1'b1 || PRESS_COUNT !== c0 + 8'h01) begin
      n_fail++;
      $display("FAIL press_state lvl=%b cnt=%h exp 1/%h",
        KEY_LEVEL, PRESS_COUNT, c0 + 8'h01);
    end
    tick(1'b0, 1'b0);
    n_chk++;
    if (KEY_PRESS !== 1'b0) begin
      n_fail++;
      $display("FAIL press_width got=%b exp=0", KEY_PRESS);
    end
    e = 0;
    for (int i = 1; i <= 20 && e == 0; i++) begin
      tick(1'b1, 1'b0);
      if (KEY_RELEASE) e = i;
    end
    n_chk++;
    if (e != D + 2 || KEY_LEVEL !== 1'b0) begin
      n_fail++;
      $display("FAIL release_edge got=%0d/%b exp=%0d/0",
        e, KEY_LEVEL, D + 2);
    end
    tick(1'b1, 1'b0);
    n_chk++;
    if (KEY_RELEASE !== 1'b0) begin
      n_fail++;
      $display("FAIL release_width got=%b exp=0", KEY_RELEASE);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] c0;
    logic pat [12];
    int np, nr;
    pat = '{0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    c0 = PRESS_COUNT;
    np = 0;
    for (int i = 0; i < 12; i++) begin
      tick(pat[i], 1'b0);
      np += KEY_PRESS;
    end
    n_chk++;
    if (np != 0 || PRESS_COUNT !== c0) begin
      n_fail++;
      $display("FAIL bounce_press np=%0d cnt=%h exp 0/%h",
        np, PRESS_COUNT, c0);
    end
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
    nr = 0;
    for (int i = 0; i < 12; i++) begin
      tick(!pat[i] ? 1'b1 : 1'b0, 1'b0);
      nr += KEY_RELEASE;
    end
    n_chk++;
    if (nr != 0 || KEY_LEVEL !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_release nr=%0d lvl=%b exp 0/1",
        nr, KEY_LEVEL);
    end
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
  endtask

  task automatic test_clear();
    tick(1'b1, 1'b1);
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    end
    n_chk++;
    if (PRESS_COUNT !== 8'h05) begin
      n_fail++;
      $display("FAIL clr_setup got=%h exp=05", PRESS_COUNT);
    end
    for (int i = 0; i < D + 1; i++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    n_chk++;
    if (KEY_PRESS !== 1'b1 || PRESS_COUNT !== 8'h01) begin
      n_fail++;
      $display("FAIL clr_collide prs=%b cnt=%h exp 1/01",
        KEY_PRESS, PRESS_COUNT);
    end
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    n_chk++;
    if (PRESS_COUNT !== 8'h00) begin
      n_fail++;
      $display("FAIL clr_alone got=%h exp=00", PRESS_COUNT);
    end
  endtask

  task automatic test_wrap();
    int np;
    tick(1'b1, 1'b1);
    np = 0;
    for (int p = 1; p <= 256; p++) begin
      for (int i = 0; i < 8; i++) begin
        tick(1'b0, 1'b0);
        np += KEY_PRESS;
      end
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
      if (p == 255) begin
        n_chk++;
        if (PRESS_COUNT !== 8'hFF) begin
          n_fail++;
          $display("FAIL wrap_255 got=%h exp=ff", PRESS_COUNT);
        end
      end
    end
    n_chk++;
    if (PRESS_COUNT !== 8'h00 || np != 256) begin
      n_fail++;
      $display("FAIL wrap_256 cnt=%h np=%0d exp 00/256",
        PRESS_COUNT, np);
    end
  endtask

  task automatic test_long();
    int e, nl, off, exp_n;
    e = 0;
    for (int i = 1; i <= 20 && e == 0; i++) begin
      tick(1'b0, 1'b0);
      if (KEY_PRESS) e = i;
    end
    nl = 0;
    off = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b0, 1'b0);
      if (KEY_LONG) begin
        nl++;
        off = i;
      end
    end
`ifdef KEY_LONG_PRESS_EN
    exp_n = 1;
`else
    exp_n = 0;
`endif
    n_chk++;
    if (e == 0 || nl != exp_n ||
        (exp_n == 1 && off != L - 1)) begin
      n_fail++;
      $display("FAIL long_press n=%0d off=%0d exp n=%0d off=%0d",
        nl, off, exp_n, L - 1);
    end
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [11:0] got, exp;
    logic k, c;
    int run, bad;
    k = 1'b1;
    run = 0;
    bad = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run == 0) begin
        k = ~k;
        run = $urandom_range(1, (i % 3 == 0) ? 16 : 6);
      end
      run--;
      c = ($urandom_range(0, 31) == 0);
      tick(k, c);
      got = {KEY_LEVEL, KEY_PRESS, KEY_RELEASE,
             KEY_LONG, PRESS_COUNT};
      exp = {m_lvl, m_prs, m_rel, m_lng, m_cnt};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        bad++;
        if (bad < 10)
          $display("FAIL random cyc=%0d got=%h exp=%h",
            i, got, exp);
      end
    end
  endtask

  initial begin
    RESET_N   = 1'b0;
    KEY_IN    = 1'b1;
    COUNT_CLR = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    test_reset();
    test_clean_press();
    test_bounce();
    test_clear();
    test_wrap();
    test_long();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
      n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce_reader.md
Name: key_debounce_reader

Overview:
- Input-side counterpart to the counter/LED output path.
- Conditions one raw, active-low, asynchronous push-button (e.g. KEY[1] on the DE0-Nano) into clean single-cycle press and release events, a debounced level, and an 8-bit press counter.
- PRESS_COUNT is intended to drive LEDG[7:0] directly, so the top level can show button activity on the same LEDs.

Parameters:
- DEBOUNCE_CYCLES, 500000, stable cycles required before a level change is accepted (10 ms at 50 MHz); legal range >= 2; benches override it with a small value.
- LONG_CYCLES, 50000000, PRESSED-state cycles before a long-press event (1 s at 50 MHz); used only with KEY_LONG_PRESS_EN.

Ports:
- EXTCLK  in  1  50 MHz system clock; all logic on the rising edge.
- RESET_N  in  1  synchronous, active-low reset (top level drives it from KEY[0]).
- KEY_IN  in  1  raw button, active-low, asynchronous to EXTCLK.
- COUNT_CLR  in  1  synchronous clear of PRESS_COUNT, active-high.
- KEY_LEVEL  out  1  debounced state; 1 = pressed.
- KEY_PRESS  out  1  one-cycle pulse on each accepted press.
- KEY_RELEASE  out  1  one-cycle pulse on each accepted release.
- KEY_LONG  out  1  one-cycle long-press pulse (optional feature).
- PRESS_COUNT  out  8  number of accepted presses, mod 256.

Behaviour:
- Reset (RESET_N = 0 at a rising edge):
  - Synchronizer flops = 1 (released); state = IDLE; debounce counter = 0; hold counter = 0.
  - KEY_LEVEL = KEY_PRESS = KEY_RELEASE = KEY_LONG = 0; PRESS_COUNT = 0x00.
  - Reset has priority over all other inputs.
- Synchronizer: 2-flop on KEY_IN, giving sync_n. All decisions use sync_n only.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: sync_n = 0 -> PRESS_WAIT, cnt <= 1.
  - PRESS_WAIT, sync_n = 1: treated as a bounce -> IDLE, cnt <= 0, no event.
  - PRESS_WAIT, sync_n = 0, cnt = DEBOUNCE_CYCLES-1: -> PRESSED; KEY_PRESS = 1 for one cycle; KEY_LEVEL <= 1; PRESS_COUNT++; cnt <= 0.
  - PRESS_WAIT, sync_n = 0, cnt < DEBOUNCE_CYCLES-1: cnt++.
  - PRESSED: sync_n = 1 -> RELEASE_WAIT, cnt <= 1.
  - RELEASE_WAIT, sync_n = 0: -> PRESSED, no event, KEY_LEVEL stays 1.
  - RELEASE_WAIT, cnt = DEBOUNCE_CYCLES-1 with sync_n = 1: -> IDLE; KEY_RELEASE = 1 for one cycle; KEY_LEVEL <= 0.
- Latency:
  - Edge 1 is the first rising edge that samples KEY_IN low.
  - KEY_PRESS and KEY_LEVEL are visible after edge DEBOUNCE_CYCLES+2.
  - Release is symmetric.
- All outputs are registered. Pulses never exceed one cycle. KEY_PRESS and KEY_RELEASE are never asserted together.
- Counter width: ceil(log2(DEBOUNCE_CYCLES)) bits minimum. No overflow is possible because the counter is compared against DEBOUNCE_CYCLES-1.
- PRESS_COUNT wraps 0xFF -> 0x00 on a press; no saturation.
- COUNT_CLR:
  - Alone: PRESS_COUNT <= 0x00.
  - Same cycle as an accepted press: PRESS_COUNT <= 0x01 (clear, then count).
- Reset mid-operation: all state is discarded. If the key is still held after reset release, it is treated as a fresh press (KEY_PRESS after DEBOUNCE_CYCLES+2 edges).
- KEY_IN held continuously: exactly one KEY_PRESS, no repeats.

Optional Feature:
- Macro: KEY_LONG_PRESS_EN.
- Defined:
  - A hold counter clears on entry to PRESSED and increments each cycle in PRESSED.
  - It also counts during RELEASE_WAIT; it is cleared only on entry to IDLE.
  - When it reaches LONG_CYCLES-1, KEY_LONG pulses for one cycle, at most once per accepted press.
  - The counter then saturates.
- Undefined: no hold counter is built; KEY_LONG is constantly 0. The port list is unchanged.

Test Plan (DEBOUNCE_CYCLES = 4, LONG_CYCLES = 10):
- Reset: RESET_N = 0 for 5 cycles with KEY_IN = 0 -> all outputs 0 and PRESS_COUNT = 0x00 throughout; after release, KEY_PRESS at edge 6.
- Clean press: KEY_IN 1 -> 0 held -> KEY_PRESS high exactly one cycle after edge 6; KEY_LEVEL = 1; PRESS_COUNT = 0x01. Release held -> KEY_RELEASE after edge 6; KEY_LEVEL = 0.
- Bounce: KEY_IN low 2 cycles, high 1, low 2, high -> no KEY_PRESS; PRESS_COUNT unchanged. Same glitch during PRESSED -> no KEY_RELEASE.
- Wrap: 256 clean presses -> PRESS_COUNT reads 0xFF after press 255 and 0x00 after press 256; exactly 256 KEY_PRESS pulses.
- Clear collision: COUNT_CLR asserted in the KEY_PRESS cycle with PRESS_COUNT = 0x05 -> PRESS_COUNT = 0x01; COUNT_CLR alone -> 0x00.
- Long press (macro defined): hold 20 cycles past KEY_PRESS -> one KEY_LONG, 9 edges after the KEY_PRESS edge. Macro undefined -> KEY_LONG is always 0.
